// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-burst link: receiver FSM states, default
// receiver geometry and the generator's burst shape.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } rxState_t;

  localparam int COUNT_W_DEF  = 4;
  localparam int WIDTH_W_DEF  = 8;
  localparam int MIN_HIGH_DEF = 1;
  localparam int MAX_HIGH_DEF = 4;
  localparam int IDLE_LOW_DEF = 6;

  localparam int GEN_PULSE_COUNT = 3;
  localparam int GEN_PULSE_WIDTH = 2;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer for the asynchronous pulse line.
// Optional 2-cycle stability filter enabled by PULSE_RX_GLITCH_FILTER_EN.
module pulse_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic signal,
  output logic sig_s
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= signal;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PULSE_RX_GLITCH_FILTER_EN
  logic r_prev;
  logic r_filt;

  // The filtered level follows only once two consecutive samples agree.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_prev <= r_sync2;
      if (r_sync2 == r_prev) begin
        r_filt <= r_prev;
      end
    end
  end

  assign sig_s = r_filt;
`else
  assign sig_s = r_sync2;
`endif

endmodule

// File: rtl/pulse_train_receiver.sv
// Pulse-burst receiver: measures pulses, ends bursts on an idle-low timeout and
// publishes count/error records over valid/ready. Glitch filter: PULSE_RX_GLITCH_FILTER_EN.
module pulse_train_receiver
  import pulse_pkg::*;
#(
  parameter int COUNT_W  = COUNT_W_DEF,
  parameter int WIDTH_W  = WIDTH_W_DEF,
  parameter int MIN_HIGH = MIN_HIGH_DEF,
  parameter int MAX_HIGH = MAX_HIGH_DEF,
  parameter int IDLE_LOW = IDLE_LOW_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               signal,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_error,
  output logic               overrun
);

  logic w_sig;

  pulse_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .signal  (signal),
    .sig_s   (w_sig)
  );

  rxState_t             r_state;
  rxState_t             w_nextState;
  logic [WIDTH_W-1:0]   r_highCnt;
  logic [WIDTH_W-1:0]   w_highCntNext;
  logic [WIDTH_W-1:0]   r_lowCnt;
  logic [WIDTH_W-1:0]   w_lowCntNext;
  logic [COUNT_W-1:0]   r_pulseCnt;
  logic [COUNT_W-1:0]   w_pulseCntNext;
  logic                 r_err;
  logic                 w_errNext;
  logic                 w_publish;

  logic [WIDTH_W-1:0]   w_highCntInc;
  logic [WIDTH_W-1:0]   w_lowCntInc;
  logic [COUNT_W-1:0]   w_pulseCntInc;
  logic                 w_badWidth;

  logic                 r_pub;
  logic [COUNT_W-1:0]   r_pubCount;
  logic                 r_pubErr;

  logic                 r_outValid;
  logic [COUNT_W-1:0]   r_outCount;
  logic                 r_outError;
  logic                 r_overrun;

  assign w_highCntInc  = (r_highCnt == '1)  ? r_highCnt  : r_highCnt + WIDTH_W'(1);
  assign w_lowCntInc   = (r_lowCnt == '1)   ? r_lowCnt   : r_lowCnt + WIDTH_W'(1);
  assign w_pulseCntInc = (r_pulseCnt == '1) ? r_pulseCnt : r_pulseCnt + COUNT_W'(1);
  assign w_badWidth    = (r_highCnt < WIDTH_W'(MIN_HIGH)) || (r_highCnt > WIDTH_W'(MAX_HIGH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_highCnt  <= '0;
      r_lowCnt   <= '0;
      r_pulseCnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_highCnt  <= w_highCntNext;
      r_lowCnt   <= w_lowCntNext;
      r_pulseCnt <= w_pulseCntNext;
      r_err      <= w_errNext;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_highCntNext  = r_highCnt;
    w_lowCntNext   = r_lowCnt;
    w_pulseCntNext = r_pulseCnt;
    w_errNext      = r_err;
    w_publish      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_sig) begin
          w_nextState    = HIGH;
          w_highCntNext  = WIDTH_W'(1);
          w_pulseCntNext = '0;
          w_errNext      = 1'b0;
        end
      end
      HIGH: begin
        if (w_sig) begin
          w_highCntNext = w_highCntInc;
        end else begin
          w_nextState    = LOW;
          w_lowCntNext   = WIDTH_W'(1);
          w_pulseCntNext = w_pulseCntInc;
          w_errNext      = r_err | w_badWidth;
        end
      end
      LOW: begin
        if (w_sig) begin
          w_nextState   = HIGH;
          w_highCntNext = WIDTH_W'(1);
        end else if (w_lowCntInc == WIDTH_W'(IDLE_LOW)) begin
          w_publish   = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_lowCntNext = w_lowCntInc;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Completed burst is staged one cycle before it reaches the output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pub      <= 1'b0;
      r_pubCount <= '0;
      r_pubErr   <= 1'b0;
    end else begin
      r_pub <= w_publish;
      if (w_publish) begin
        r_pubCount <= r_pulseCnt;
        r_pubErr   <= r_err;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_outValid <= 1'b0;
      r_outCount <= '0;
      r_outError <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (r_pub) begin
      if (!r_outValid || out_ready) begin
        r_outValid <= 1'b1;
        r_outCount <= r_pubCount;
        r_outError <= r_pubErr;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign out_count = r_outCount;
  assign out_error = r_outError;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_pulse_train_receiver.sv
// Directed, table-driven bench for pulse_train_receiver.
// Honours PULSE_RX_GLITCH_FILTER_EN when the design is built with it.
module tb_pulse_train_receiver;
  import pulse_pkg::*;

  localparam int idleLow = IDLE_LOW_DEF;
`ifdef PULSE_RX_GLITCH_FILTER_EN
  localparam int latTicks   = idleLow + 5;
  localparam int glitchExp  = 2;
  localparam int minPulseW  = 2;
`else
  localparam int latTicks   = idleLow + 3;
  localparam int glitchExp  = 3;
  localparam int minPulseW  = 1;
`endif

  logic       clock;
  logic       reset_n;
  logic       signal;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_count;
  logic       out_error;
  logic       overrun;

  int errors;
  int checks;

  typedef struct {
    string name;
    int    pulses;
    int    highW;
    int    lowW;
    int    expCount;
    int    expErr;
  } vec_t;

  vec_t vecs[6];

  pulse_train_receiver dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .signal    (signal),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_error (out_error),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives a burst; the line is left low with no edge consumed after the last pulse.
  task automatic applyStimulus(input int numPulses, input int highW, input int lowW);
    for (int p = 0; p < numPulses; p++) begin
      signal = 1'b1;
      repeat (highW) tick();
      signal = 1'b0;
      if (p != numPulses - 1) repeat (lowW) tick();
    end
  endtask

  task automatic waitValid(input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    checkOutput({name, " latency"}, lat, latTicks);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sawValid;
    errors    = 0;
    checks    = 0;
    reset_n   = 1'b0;
    signal    = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{"three pulses",      3, 2, 2, 3, 0};
    vecs[1] = '{"wide pulse",        1, 6, 2, 1, 1};
    vecs[2] = '{"min width",         2, minPulseW, 2, 2, 0};
    vecs[3] = '{"max width",         2, 4, 2, 2, 0};
    vecs[4] = '{"over max",          3, 5, 2, 3, 1};
    vecs[5] = '{"gap below timeout", 4, 2, 5, 4, 0};

    #1;
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_count", int'(out_count), 0);
    checkOutput("reset out_error", int'(out_error), 0);
    checkOutput("reset overrun",   int'(overrun),   0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].pulses, vecs[v].highW, vecs[v].lowW);
      waitValid(vecs[v].name);
      checkOutput({vecs[v].name, " count"},   int'(out_count), vecs[v].expCount);
      checkOutput({vecs[v].name, " error"},   int'(out_error), vecs[v].expErr);
      checkOutput({vecs[v].name, " overrun"}, int'(overrun),   0);
      tick();
      checkOutput({vecs[v].name, " valid drop"}, int'(out_valid), 0);
      repeat (3) tick();
    end

    // Publish lands in the same cycle a pending record is accepted.
    out_ready = 1'b0;
    applyStimulus(2, 2, 2);
    waitValid("same-cycle first");
    checkOutput("same-cycle first count", int'(out_count), 2);
    applyStimulus(3, 2, 2);
    repeat (latTicks - 1) tick();
    checkOutput("same-cycle held valid", int'(out_valid), 1);
    checkOutput("same-cycle held count", int'(out_count), 2);
    out_ready = 1'b1;
    tick();
    checkOutput("same-cycle valid",   int'(out_valid), 1);
    checkOutput("same-cycle count",   int'(out_count), 3);
    checkOutput("same-cycle error",   int'(out_error), 0);
    checkOutput("same-cycle overrun", int'(overrun),   0);
    tick();
    checkOutput("same-cycle drain", int'(out_valid), 0);
    repeat (3) tick();

    applyStimulus(20, 2, 2);
    waitValid("saturate");
    checkOutput("saturate count", int'(out_count), 15);
    checkOutput("saturate error", int'(out_error), 0);
    repeat (3) tick();

    signal = 1'b1;
    sawValid = 0;
    repeat (40) begin
      tick();
      if (out_valid) sawValid = 1;
    end
    checkOutput("stuck high no publish", sawValid, 0);
    signal = 1'b0;
    waitValid("stuck high");
    checkOutput("stuck high count", int'(out_count), 1);
    checkOutput("stuck high error", int'(out_error), 1);
    repeat (3) tick();

    signal = 1'b1; repeat (2) tick();
    signal = 1'b0; repeat (2) tick();
    signal = 1'b1; tick();
    signal = 1'b0; repeat (2) tick();
    signal = 1'b1; repeat (2) tick();
    signal = 1'b0;
    waitValid("glitch");
    checkOutput("glitch count", int'(out_count), glitchExp);
    checkOutput("glitch error", int'(out_error), 0);
    repeat (3) tick();

    out_ready = 1'b0;
    applyStimulus(2, 2, 2);
    waitValid("overrun first");
    checkOutput("overrun first count", int'(out_count), 2);
    checkOutput("overrun before",      int'(overrun),   0);
    applyStimulus(4, 2, 2);
    repeat (latTicks + 2) tick();
    checkOutput("overrun held valid", int'(out_valid), 1);
    checkOutput("overrun held count", int'(out_count), 2);
    checkOutput("overrun flag",       int'(overrun),   1);
    out_ready = 1'b1;
    tick();
    checkOutput("overrun drain valid", int'(out_valid), 0);
    checkOutput("overrun sticky",      int'(overrun),   1);
    out_ready = 1'b0;
    repeat (3) tick();

    // Pending record plus sticky overrun, then reset lands mid-pulse.
    applyStimulus(1, 2, 2);
    waitValid("pre-reset");
    checkOutput("pre-reset count", int'(out_count), 1);
    signal = 1'b1;
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid reset valid",   int'(out_valid), 0);
    checkOutput("mid reset count",   int'(out_count), 0);
    checkOutput("mid reset error",   int'(out_error), 0);
    checkOutput("mid reset overrun", int'(overrun),   0);
    signal = 1'b0;
    tick();
    reset_n = 1'b1;
    sawValid = 0;
    repeat (30) begin
      tick();
      if (out_valid) sawValid = 1;
    end
    checkOutput("no record after reset", sawValid, 0);

    // Line already high when reset releases.
    out_ready = 1'b1;
    reset_n = 1'b0;
    signal  = 1'b1;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    signal = 1'b0;
    waitValid("high at release");
    checkOutput("high at release count", int'(out_count), 1);
    checkOutput("high at release error", int'(out_error), 0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
